decode_miinst_queue: RTL and testbench

Parametrised micro-instruction queue between the rename stage and the decode phase. It buffers up to DEPTH micro-instructions so that a decode stall does not block rename. It presents the oldest entry to decode with a valid/stall handshake. Flush discards all contents in one cycle, and the block keeps a saturating count of refused enqueue attempts for performance monitoring.

---
 rtl/decode_miinst_queue.sv | 74 +++++++
 tb/tb_decode_miinst_queue.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/decode_miinst_queue.sv
// Micro-instruction queue between rename and decode: circular buffer with
// valid/stall handshake, single-cycle flush and a saturating refused-enqueue counter.
module decode_miinst_queue #(
    parameter int DEPTH     = 4,
    parameter int W         = 64,
    parameter int AF_MARGIN = 1,
    parameter int DROP_W    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enq_valid,
    input  logic [W-1:0]                 enq_miinst,
    output logic                         enq_ready,
    output logic                         deq_valid,
    output logic [W-1:0]                 deq_miinst,
    input  logic                         stall,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         almost_full,
    output logic [DROP_W-1:0]            drop_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [PW-1:0]           head, tail;
    logic                    enq_fire, deq_fire, drop;

    // Handshake outputs derive from registered count only, so no input reaches an output.
    assign enq_ready   = (count != CW'(DEPTH));
    assign deq_valid   = (count != '0);
    assign almost_full = (count >= CW'(DEPTH - AF_MARGIN));
    assign deq_miinst  = deq_valid ? mem[head] : '0;

    assign enq_fire = enq_valid && enq_ready && !flush;
    assign deq_fire = deq_valid && !stall && !flush;
    assign drop     = enq_valid && !enq_ready && !flush;

    // Payload storage is intentionally unreset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (enq_fire)
            mem[tail] <= enq_miinst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq_fire)
                tail <= tail + PW'(1);
            if (deq_fire)
                head <= head + PW'(1);
            case ({enq_fire, deq_fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Survives flush; only reset clears the performance counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            drop_cnt <= '0;
        else if (drop && drop_cnt != '1)
            drop_cnt <= drop_cnt + DROP_W'(1);
    end
endmodule

// File: tb/tb_decode_miinst_queue.sv
// Directed bench for decode_miinst_queue; a second instance with DROP_W=2
// shares the stimulus to exercise drop counter saturation.
module tb_decode_miinst_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        enq_valid, stall, flush;
    logic [63:0] enq_miinst;
    logic        enq_ready, deq_valid, almost_full;
    logic [63:0] deq_miinst;
    logic [2:0]  count;
    logic [15:0] drop_cnt;

    logic        enq_ready2, deq_valid2, almost_full2;
    logic [63:0] deq_miinst2;
    logic [2:0]  count2;
    logic [1:0]  drop_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_miinst_queue #(.DEPTH(4), .W(64), .AF_MARGIN(1), .DROP_W(16)) u_dut (
        .clk(clk), .rst(rst), .enq_valid(enq_valid), .enq_miinst(enq_miinst),
        .enq_ready(enq_ready), .deq_valid(deq_valid), .deq_miinst(deq_miinst),
        .stall(stall), .flush(flush), .count(count), .almost_full(almost_full),
        .drop_cnt(drop_cnt)
    );

    decode_miinst_queue #(.DEPTH(4), .W(64), .AF_MARGIN(1), .DROP_W(2)) u_sat (
        .clk(clk), .rst(rst), .enq_valid(enq_valid), .enq_miinst(enq_miinst),
        .enq_ready(enq_ready2), .deq_valid(deq_valid2), .deq_miinst(deq_miinst2),
        .stall(stall), .flush(flush), .count(count2), .almost_full(almost_full2),
        .drop_cnt(drop_cnt2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; enq_valid = 1'b0; enq_miinst = '0; stall = 1'b0; flush = 1'b0;
        #12;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_deq_valid", 64'(deq_valid), 64'd0);
        chk("rst_deq_miinst", deq_miinst, 64'd0);
        chk("rst_enq_ready", 64'(enq_ready), 64'd1);
        chk("rst_almost_full", 64'(almost_full), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        rst = 1'b0;

        // single enqueue, visible one cycle later, consumed the next
        enq_valid = 1'b1; enq_miinst = 64'hA5;
        tick();
        enq_valid = 1'b0;
        chk("single_valid", 64'(deq_valid), 64'd1);
        chk("single_data", deq_miinst, 64'hA5);
        chk("single_count", 64'(count), 64'd1);
        tick();
        chk("single_drain_count", 64'(count), 64'd0);
        chk("single_drain_data", deq_miinst, 64'd0);

        // fill under stall and overflow by two
        stall = 1'b1; enq_valid = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            enq_miinst = 64'(i);
            tick();
            if (i == 2) chk("fill_af_at2", 64'(almost_full), 64'd0);
            if (i == 3) chk("fill_af_at3", 64'(almost_full), 64'd1);
            if (i == 4) chk("fill_ready_at4", 64'(enq_ready), 64'd0);
        end
        chk("fill_count", 64'(count), 64'd4);
        chk("fill_drop", 64'(drop_cnt), 64'd2);
        chk("fill_drop_sat_inst", 64'(drop_cnt2), 64'd2);
        enq_valid = 1'b0; stall = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("drain_order_%0d", i), deq_miinst, 64'(i));
            tick();
        end
        chk("drain_empty", 64'(deq_valid), 64'd0);

        // steady enq+deq at count=2 across pointer wrap
        stall = 1'b1; enq_valid = 1'b1;
        enq_miinst = 64'h10; tick();
        enq_miinst = 64'h11; tick();
        stall = 1'b0;
        for (int k = 0; k < 10; k++) begin
            enq_miinst = 64'h12 + 64'(k);
            chk($sformatf("wrap_head_%0d", k), deq_miinst, 64'h10 + 64'(k));
            tick();
            chk($sformatf("wrap_count_%0d", k), 64'(count), 64'd2);
        end

        // full with dequeue: enqueue refused, no pass-through
        stall = 1'b1;
        enq_miinst = 64'h1C; tick();
        enq_miinst = 64'h1D; tick();
        chk("full_count", 64'(count), 64'd4);
        stall = 1'b0; enq_miinst = 64'h1E;
        chk("full_ready", 64'(enq_ready), 64'd0);
        tick();
        chk("full_deq_count", 64'(count), 64'd3);
        chk("full_deq_drop", 64'(drop_cnt), 64'd3);
        chk("full_deq_head", deq_miinst, 64'h1B);

        // flush with concurrent enq and deq
        flush = 1'b1; enq_miinst = 64'h20;
        tick();
        flush = 1'b0; enq_valid = 1'b0;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", 64'(deq_valid), 64'd0);
        chk("flush_ready", 64'(enq_ready), 64'd1);
        chk("flush_drop", 64'(drop_cnt), 64'd3);
        chk("flush_data", deq_miinst, 64'd0);

        // async reset between edges
        stall = 1'b1; enq_valid = 1'b1;
        enq_miinst = 64'h30; tick();
        enq_miinst = 64'h31; tick();
        enq_valid = 1'b0;
        chk("pre_arst_count", 64'(count), 64'd2);
        #2 rst = 1'b1;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_valid", 64'(deq_valid), 64'd0);
        chk("arst_drop", 64'(drop_cnt), 64'd0);
        chk("arst_drop_sat_inst", 64'(drop_cnt2), 64'd0);
        #1 rst = 1'b0;
        enq_valid = 1'b1; enq_miinst = 64'h40;
        tick();
        enq_valid = 1'b0;
        chk("post_rst_count", 64'(count), 64'd1);
        chk("post_rst_data", deq_miinst, 64'h40);
        stall = 1'b0;
        tick();
        chk("post_rst_drain", 64'(count), 64'd0);

        // saturation: fill then hold enq_valid for 6 refused cycles
        stall = 1'b1; enq_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            enq_miinst = 64'h50 + 64'(i);
            tick();
            if (i == 6) chk("sat_reach", 64'(drop_cnt2), 64'd3);
        end
        enq_valid = 1'b0;
        chk("sat_held", 64'(drop_cnt2), 64'd3);
        chk("sat_wide_drop", 64'(drop_cnt), 64'd6);
        chk("sat_count", 64'(count), 64'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
